// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: start with operands in, busy/done and result flags out.
// master drives the request side, slave is the subtractor itself.
interface serial_subtractor_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;
  logic         zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first through one full-subtractor cell: W SHIFT cycles, then a one-cycle done.
// No backpressure: start is only accepted in IDLE and is dropped (not queued) otherwise.
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  diff_q, diff_d;
  logic [CW-1:0] count_q, count_d;
  logic          bor_q, bor_d;
  logic          a_msb_q, a_msb_d;
  logic          b_msb_q, b_msb_d;
  logic          borrow_q, borrow_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;

  logic x, y, d, bor_next;

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    count_d  = count_q;
    bor_d    = bor_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    x        = sa_q[0];
    y        = sb_q[0];
    d        = x ^ y ^ bor_q;
    bor_next = (~x & y) | (~(x ^ y) & bor_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sa_d    = bus.a;
          sb_d    = bus.b;
          a_msb_d = bus.a[W-1];
          b_msb_d = bus.b[W-1];
          bor_d   = 1'b0;
          count_d = '0;
        end
      end
      SHIFT: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = {d, res_q[W-1:1]};
        bor_d   = bor_next;
        count_d = count_q + CW'(1);
        // The last bit lands in res_d this edge, so the result is published straight from it.
        if (count_q == CW'(W - 1)) begin
          state_d  = DONE;
          diff_d   = {d, res_q[W-1:1]};
          borrow_d = bor_next;
          ovf_d    = (a_msb_q ^ b_msb_q) & (d ^ a_msb_q);
          zero_d   = (diff_d == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      count_q  <= '0;
      bor_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      count_q  <= count_d;
      bor_q    <= bor_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = ovf_q;
  assign bus.zero       = zero_q;
endmodule
